// File: rtl/seq_detect_arbiter.sv
// Round-robin time-shared "10011" Moore detector over N serial channels.
// Optional per-channel saturating match counters: define MATCH_CNT_EN.
module seq_detect_arbiter #(
   parameter int N     = 4,
   parameter int CH_W  = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_i,
   input  logic [N-1:0]     bit_in_i,
   input  logic [N-1:0]     clr_i,
   input  logic [CH_W-1:0]  cnt_sel_i,
   output logic [N-1:0]     gnt_o,
   output logic             match_valid_o,
   output logic [CH_W-1:0]  match_ch_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] cnt_out_o
);

   // state | meaning: S0 idle | S1 "1" | S2 "10" | S3 "100" | S4 "1001" | S5 "10011" seen
   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} state_t;

   state_t          ctx_q [N];
   state_t          ctx_d [N];
   state_t          nxt;
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [CH_W-1:0] gnt_idx, idx;
   logic            gnt_any;
   logic [N-1:0]    elig;
   logic            match_d;
   logic            match_valid_q, busy_q;
   logic [CH_W-1:0] match_ch_q;

   function automatic state_t next_state(input state_t s, input logic b);
      case (s)
         S0:      return b ? S1 : S0;
         S1:      return b ? S1 : S2;
         S2:      return b ? S1 : S3;
         S3:      return b ? S4 : S0;
         S4:      return b ? S5 : S2;
         S5:      return b ? S1 : S2;
         default: return S0;
      endcase
   endfunction

   // Search starts just above the last winner so every requester is served in turn.
   always_comb begin
      elig    = req_i & ~clr_i;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      gnt_o   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = CH_W'((int'(ptr_q) + k) % N);
         if (!gnt_any && elig[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
      if (gnt_any) gnt_o[gnt_idx] = 1'b1;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         ctx_d[i] = ctx_q[i];
         if (clr_i[i]) ctx_d[i] = S0;
      end
      nxt = next_state(ctx_q[gnt_idx], bit_in_i[gnt_idx]);
      if (gnt_any) ctx_d[gnt_idx] = nxt;
      ptr_d   = gnt_any ? gnt_idx : ptr_q;
      match_d = gnt_any && (nxt == S5);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) ctx_q[i] <= S0;
         ptr_q         <= CH_W'(N - 1);
         match_valid_q <= 1'b0;
         match_ch_q    <= '0;
         busy_q        <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) ctx_q[i] <= ctx_d[i];
         ptr_q         <= ptr_d;
         match_valid_q <= match_d;
         if (match_d) match_ch_q <= gnt_idx;
         busy_q        <= gnt_any;
      end
   end

   assign match_valid_o = match_valid_q;
   assign match_ch_o    = match_ch_q;
   assign busy_o        = busy_q;

`ifdef MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q [N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (clr_i[i])
               cnt_q[i] <= '0;
            else if (match_d && gnt_idx == CH_W'(i) && cnt_q[i] != {CNT_W{1'b1}})
               cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   assign cnt_out_o = cnt_q[cnt_sel_i];
`else
   logic unused_cnt_sel;
   assign unused_cnt_sel = ^cnt_sel_i;
   assign cnt_out_o      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench for seq_detect_arbiter: stimulus queues expected grants and
// match pulses, a negedge monitor pops and compares them.
module tb_seq_detect_arbiter;
   localparam int N = 4, CH_W = 2, CNT_W = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0, bit_in = '0, clr = '0;
   logic [CH_W-1:0] cnt_sel = '0;
   logic [N-1:0]    gnt;
   logic            match_valid, busy;
   logic [CH_W-1:0] match_ch;
   logic [CNT_W-1:0] cnt_out;

   seq_detect_arbiter #(.N(N), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req_i(req), .bit_in_i(bit_in), .clr_i(clr),
      .cnt_sel_i(cnt_sel), .gnt_o(gnt), .match_valid_o(match_valid),
      .match_ch_o(match_ch), .busy_o(busy), .cnt_out_o(cnt_out));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rst_cnt = 0;
   always @(posedge rst) rst_cnt = rst_cnt + 1;

   typedef struct { int ch; int cyc; } mexp_t;
   mexp_t        mq[$];
   logic [N-1:0] gq[$];
   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: grant and busy each stepped cycle, match pulses against the queue.
   logic [N-1:0] prev_gnt = '0;
   int           seen_rst = 0;
   always @(negedge clk) begin
      logic [N-1:0] eg;
      mexp_t m;
      if (rst_cnt != seen_rst) begin
         prev_gnt = '0;
         seen_rst = rst_cnt;
      end
      if (gq.size() > 0) begin
         eg = gq.pop_front();
         chk("gnt", 32'(gnt), 32'(eg));
         chk("busy", 32'(busy), 32'(prev_gnt != '0));
         prev_gnt = eg;
      end
      if (match_valid === 1'b1) begin
         if (mq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_match: got match_ch=%0d expected no pulse (cycle %0d)", match_ch, cyc);
         end else begin
            m = mq.pop_front();
            chk("match_ch", 32'(match_ch), 32'(m.ch));
            chk("match_cycle", 32'(cyc), 32'(m.cyc));
         end
      end else if (mq.size() > 0 && mq[0].cyc <= cyc) begin
         m = mq.pop_front();
         n_tests++; n_fail++;
         $display("FAIL missing_match: got no pulse expected ch=%0d at cycle %0d", m.ch, m.cyc);
      end
   end

   task automatic step(input logic [N-1:0] r, input logic [N-1:0] b, input logic [N-1:0] c,
                       input logic [N-1:0] eg, input int ech);
      mexp_t m;
      @(posedge clk); #1;
      req = r; bit_in = b; clr = c;
      gq.push_back(eg);
      if (ech >= 0) begin
         m.ch = ech; m.cyc = cyc + 1;
         mq.push_back(m);
      end
   endtask

   task automatic do_reset();
      step('0, '0, '0, '0, -1);
      @(negedge clk); #1;
      rst = 1'b1;
      step('0, '0, '0, '0, -1);
      step('0, '0, '0, '0, -1);
      rst = 1'b0;
   endtask

   logic p5 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic p9 [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic p4 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int i0, i2;
      step('0, '0, '0, '0, -1);
      step('0, '0, '0, '0, -1);
      chk("rst_match_valid", 32'(match_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_match_ch", 32'(match_ch), 0);
      rst = 1'b0;

      // Single requester, channel 0.
      for (int k = 0; k < 5; k++)
         step(4'b0001, {3'b0, p5[k]}, '0, 4'b0001, (k == 4) ? 0 : -1);

      // Overlapping detection, channel 1.
      do_reset();
      for (int k = 0; k < 9; k++)
         step(4'b0010, {2'b0, p9[k], 1'b0}, '0, 4'b0010, (k == 4 || k == 8) ? 1 : -1);

      // Fairness with all channels requesting.
      do_reset();
      for (int k = 0; k < 8; k++)
         step(4'b1111, '0, '0, 4'(1 << (k % 4)), -1);

      // Interleaved channels 0 and 2 with independent contexts.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         i0 = (k + 1) / 2; if (i0 > 4) i0 = 4;
         i2 = k / 2;       if (i2 > 4) i2 = 4;
         step(4'b0101, {1'b0, p5[i2], 1'b0, p5[i0]}, '0,
              (k % 2 == 0) ? 4'b0001 : 4'b0100,
              (k == 8) ? 0 : (k == 9) ? 2 : -1);
      end

      // clr on channel 3 while its context sits in S4.
      do_reset();
      for (int k = 0; k < 4; k++)
         step(4'b1000, {p5[k], 3'b0}, '0, 4'b1000, -1);
      step(4'b1000, 4'b1000, 4'b1000, 4'b0000, -1);
      step(4'b1000, 4'b1000, '0, 4'b1000, -1);
      for (int k = 0; k < 4; k++)
         step(4'b1000, {p4[k], 3'b0}, '0, 4'b1000, (k == 3) ? 3 : -1);

      // Asynchronous reset mid-cycle with channel 0 in S4.
      for (int k = 0; k < 4; k++)
         step(4'b0001, {3'b0, p5[k]}, '0, 4'b0001, -1);
      step('0, '0, '0, '0, -1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_match_valid", 32'(match_valid), 0);
      chk("async_rst_match_ch", 32'(match_ch), 0);
      rst = 1'b0;
      step(4'b0001, 4'b0001, '0, 4'b0001, -1);
      for (int k = 0; k < 4; k++)
         step(4'b0001, {3'b0, p4[k]}, '0, 4'b0001, (k == 3) ? 0 : -1);

`ifdef MATCH_CNT_EN
      do_reset();
      for (int k = 0; k < 5; k++)
         step(4'b0001, {3'b0, p5[k]}, '0, 4'b0001, (k == 4) ? 0 : -1);
      for (int r = 0; r < 255; r++)
         for (int k = 0; k < 4; k++)
            step(4'b0001, {3'b0, p4[k]}, '0, 4'b0001, (k == 3) ? 0 : -1);
      step('0, '0, '0, '0, -1);
      cnt_sel = 2'd0;
      #1 chk("cnt_saturated", 32'(cnt_out), 255);
      cnt_sel = 2'd1;
      #1 chk("cnt_other_ch", 32'(cnt_out), 0);
`else
      #1 chk("cnt_out_tied", 32'(cnt_out), 0);
`endif

      for (int k = 0; k < 3; k++)
         step('0, '0, '0, '0, -1);
      @(negedge clk); #1;
      while (mq.size() > 0) begin
         mexp_t m;
         m = mq.pop_front();
         n_tests++; n_fail++;
         $display("FAIL missing_match: got no pulse expected ch=%0d at cycle %0d", m.ch, m.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
